// File: rtl/hyper_pad_arbiter.sv
// Shares one HyperBus pad set between two controllers; whole-transaction round-robin grants with a bus-idle turnaround.
// Grant is valid one cycle after the request is seen. Pad forwarding is a pure mux; a non-owner waits by holding req_i.
module hyper_pad_arbiter #(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    input  logic [1:0] r0_cs_ni,
    input  logic       r0_ck_i,
    input  logic       r0_ck_ni,
    input  logic       r0_rwds_i,
    input  logic       r0_rwds_oe_i,
    output logic       r0_rwds_o,
    input  logic [7:0] r0_dq_i,
    input  logic       r0_dq_oe_i,
    output logic [7:0] r0_dq_o,
    input  logic       r0_reset_ni,
    input  logic [1:0] r1_cs_ni,
    input  logic       r1_ck_i,
    input  logic       r1_ck_ni,
    input  logic       r1_rwds_i,
    input  logic       r1_rwds_oe_i,
    output logic       r1_rwds_o,
    input  logic [7:0] r1_dq_i,
    input  logic       r1_dq_oe_i,
    output logic [7:0] r1_dq_o,
    input  logic       r1_reset_ni,
    output logic [1:0] pad_cs_no,
    output logic       pad_ck_o,
    output logic       pad_ck_no,
    output logic       pad_rwds_o,
    output logic       pad_rwds_oe_o,
    input  logic       pad_rwds_i,
    output logic [7:0] pad_dq_o,
    output logic       pad_dq_oe_o,
    input  logic [7:0] pad_dq_i,
    output logic       pad_reset_no,
    output logic [1:0] owner_o,
    output logic       err_o
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_GNT0 = 2'b01;
    localparam logic [1:0] ST_GNT1 = 2'b10;
    localparam logic [1:0] ST_TURN = 2'b11;
    localparam logic [3:0] CNT_LOAD = 4'(TURNAROUND - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       err_q, err_d;
    logic       win;

    // On a tie the requester that did not own the pads last time wins.
    always_comb begin
        win = ~last_q;
        if (req_i == 2'b01) win = 1'b0;
        if (req_i == 2'b10) win = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    state_d = win ? ST_GNT1 : ST_GNT0;
                    last_d  = win;
                end
            end
            ST_GNT0: begin
                if (!req_i[0] && r0_cs_ni == 2'b11) begin
                    state_d = ST_TURN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_GNT1: begin
                if (!req_i[1] && r1_cs_ni == 2'b11) begin
                    state_d = ST_TURN;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                if (cnt_q == 4'd0) begin
                    if (|req_i) begin
                        state_d = win ? ST_GNT1 : ST_GNT0;
                        last_d  = win;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
        err_d = (state_q != ST_GNT0 && r0_cs_ni != 2'b11) ||
                (state_q != ST_GNT1 && r1_cs_ni != 2'b11);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o        = {state_q == ST_GNT1, state_q == ST_GNT0};
    assign owner_o      = state_q;
    assign err_o        = err_q;
    assign pad_reset_no = r0_reset_ni & r1_reset_ni;

    // Pads are parked in IDLE/TURN; only the owner reaches them or hears them.
    always_comb begin
        pad_cs_no     = 2'b11;
        pad_ck_o      = 1'b0;
        pad_ck_no     = 1'b1;
        pad_rwds_o    = 1'b0;
        pad_rwds_oe_o = 1'b0;
        pad_dq_o      = 8'h00;
        pad_dq_oe_o   = 1'b0;
        r0_dq_o       = 8'h00;
        r0_rwds_o     = 1'b0;
        r1_dq_o       = 8'h00;
        r1_rwds_o     = 1'b0;
        if (state_q == ST_GNT0) begin
            pad_cs_no     = r0_cs_ni;
            pad_ck_o      = r0_ck_i;
            pad_ck_no     = r0_ck_ni;
            pad_rwds_o    = r0_rwds_i;
            pad_rwds_oe_o = r0_rwds_oe_i;
            pad_dq_o      = r0_dq_i;
            pad_dq_oe_o   = r0_dq_oe_i;
            r0_dq_o       = pad_dq_i;
            r0_rwds_o     = pad_rwds_i;
        end else if (state_q == ST_GNT1) begin
            pad_cs_no     = r1_cs_ni;
            pad_ck_o      = r1_ck_i;
            pad_ck_no     = r1_ck_ni;
            pad_rwds_o    = r1_rwds_i;
            pad_rwds_oe_o = r1_rwds_oe_i;
            pad_dq_o      = r1_dq_i;
            pad_dq_oe_o   = r1_dq_oe_i;
            r1_dq_o       = pad_dq_i;
            r1_rwds_o     = pad_rwds_i;
        end
    end
endmodule

// File: tb/tb_hyper_pad_arbiter.sv
// Directed bench for hyper_pad_arbiter with TURNAROUND=2.
module tb_hyper_pad_arbiter;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [1:0] req_i;
    logic [1:0] gnt_o;
    logic [1:0] r0_cs_ni, r1_cs_ni;
    logic       r0_ck_i, r0_ck_ni, r1_ck_i, r1_ck_ni;
    logic       r0_rwds_i, r0_rwds_oe_i, r0_rwds_o, r1_rwds_i, r1_rwds_oe_i, r1_rwds_o;
    logic [7:0] r0_dq_i, r0_dq_o, r1_dq_i, r1_dq_o;
    logic       r0_dq_oe_i, r1_dq_oe_i, r0_reset_ni, r1_reset_ni;
    logic [1:0] pad_cs_no;
    logic       pad_ck_o, pad_ck_no, pad_rwds_o, pad_rwds_oe_o, pad_rwds_i;
    logic [7:0] pad_dq_o, pad_dq_i;
    logic       pad_dq_oe_o, pad_reset_no;
    logic [1:0] owner_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    hyper_pad_arbiter #(.TURNAROUND(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .r0_cs_ni(r0_cs_ni), .r0_ck_i(r0_ck_i), .r0_ck_ni(r0_ck_ni),
        .r0_rwds_i(r0_rwds_i), .r0_rwds_oe_i(r0_rwds_oe_i), .r0_rwds_o(r0_rwds_o),
        .r0_dq_i(r0_dq_i), .r0_dq_oe_i(r0_dq_oe_i), .r0_dq_o(r0_dq_o), .r0_reset_ni(r0_reset_ni),
        .r1_cs_ni(r1_cs_ni), .r1_ck_i(r1_ck_i), .r1_ck_ni(r1_ck_ni),
        .r1_rwds_i(r1_rwds_i), .r1_rwds_oe_i(r1_rwds_oe_i), .r1_rwds_o(r1_rwds_o),
        .r1_dq_i(r1_dq_i), .r1_dq_oe_i(r1_dq_oe_i), .r1_dq_o(r1_dq_o), .r1_reset_ni(r1_reset_ni),
        .pad_cs_no(pad_cs_no), .pad_ck_o(pad_ck_o), .pad_ck_no(pad_ck_no),
        .pad_rwds_o(pad_rwds_o), .pad_rwds_oe_o(pad_rwds_oe_o), .pad_rwds_i(pad_rwds_i),
        .pad_dq_o(pad_dq_o), .pad_dq_oe_o(pad_dq_oe_o), .pad_dq_i(pad_dq_i),
        .pad_reset_no(pad_reset_no), .owner_o(owner_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 2'b00;
        r0_cs_ni = 2'b11; r1_cs_ni = 2'b11;
        r0_ck_i = 1'b0; r0_ck_ni = 1'b1; r1_ck_i = 1'b0; r1_ck_ni = 1'b1;
        r0_rwds_i = 1'b0; r0_rwds_oe_i = 1'b0; r1_rwds_i = 1'b0; r1_rwds_oe_i = 1'b0;
        r0_dq_i = 8'h00; r0_dq_oe_i = 1'b0; r1_dq_i = 8'h00; r1_dq_oe_i = 1'b0;
        r0_reset_ni = 1'b1; r1_reset_ni = 1'b1;
        pad_rwds_i = 1'b1; pad_dq_i = 8'hFF;
        #3;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_owner", 32'(owner_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_pad_cs", 32'(pad_cs_no), 32'h3);
        chk("rst_pad_ckn", 32'(pad_ck_no), 32'h1);
        chk("rst_r0_dq", 32'(r0_dq_o), 32'h0);
        chk("rst_r0_rwds", 32'(r0_rwds_o), 32'h0);
        tick(); tick();
        rst_ni = 1'b1;
        tick(); tick();

        // Single request, one-cycle grant, zero-cycle forwarding.
        req_i = 2'b01;
        chk("idle_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk("g0_gnt", 32'(gnt_o), 32'h1);
        chk("g0_owner", 32'(owner_o), 32'h1);
        r0_dq_i = 8'hA5; r0_dq_oe_i = 1'b1; r0_cs_ni = 2'b10; r0_ck_i = 1'b1;
        #1;
        chk("g0_pad_dq", 32'(pad_dq_o), 32'hA5);
        chk("g0_pad_dq_oe", 32'(pad_dq_oe_o), 32'h1);
        chk("g0_pad_cs", 32'(pad_cs_no), 32'h2);
        chk("g0_pad_ck", 32'(pad_ck_o), 32'h1);
        chk("g0_r0_dq", 32'(r0_dq_o), 32'hFF);
        chk("g0_r1_dq", 32'(r1_dq_o), 32'h0);

        // Request drops while CS still low: grant must hold.
        req_i = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_gnt", 32'(gnt_o), 32'h1);
        end
        r0_cs_ni = 2'b11; r0_ck_i = 1'b0; r0_dq_oe_i = 1'b0;
        tick();
        chk("rel_turn_owner", 32'(owner_o), 32'h3);
        chk("rel_turn_gnt", 32'(gnt_o), 32'h0);
        tick();
        chk("rel_turn2_owner", 32'(owner_o), 32'h3);
        tick();
        chk("rel_idle_owner", 32'(owner_o), 32'h0);

        // Non-owner CS is blocked and flagged one cycle later.
        req_i = 2'b01;
        tick();
        chk("viol_owner", 32'(owner_o), 32'h1);
        r1_cs_ni = 2'b10; pad_dq_i = 8'h3C;
        #1;
        chk("viol_pad_cs", 32'(pad_cs_no), 32'h3);
        chk("viol_r1_dq", 32'(r1_dq_o), 32'h0);
        chk("viol_err_early", 32'(err_o), 32'h0);
        tick();
        chk("viol_err", 32'(err_o), 32'h1);
        chk("viol_state", 32'(owner_o), 32'h1);
        r1_cs_ni = 2'b11;
        r1_reset_ni = 1'b0;
        #1;
        chk("reset_and", 32'(pad_reset_no), 32'h0);
        r1_reset_ni = 1'b1;
        tick();
        chk("viol_err_clear", 32'(err_o), 32'h0);

        // Release r0 with r1 pending: two parked cycles then GRANT1.
        req_i = 2'b10;
        tick();
        chk("h01_turn_a", 32'(owner_o), 32'h3);
        chk("h01_parked_ckn", 32'(pad_ck_no), 32'h1);
        tick();
        chk("h01_turn_b", 32'(owner_o), 32'h3);
        tick();
        chk("h01_gnt", 32'(gnt_o), 32'h2);
        r1_ck_i = 1'b1; r1_dq_i = 8'h5A;
        #1;
        chk("g1_pad_ck", 32'(pad_ck_o), 32'h1);
        chk("g1_pad_dq", 32'(pad_dq_o), 32'h5A);
        chk("g1_r1_dq", 32'(r1_dq_o), 32'h3C);
        chk("g1_r0_dq", 32'(r0_dq_o), 32'h0);
        r1_ck_i = 1'b0;

        // Release r1 with r0 pending: back to GRANT0.
        req_i = 2'b01;
        tick(); tick();
        chk("h10_turn", 32'(owner_o), 32'h3);
        tick();
        chk("h10_gnt", 32'(gnt_o), 32'h1);

        // Releaser re-requests during TURN while other pending: other wins.
        req_i = 2'b10;
        tick();
        chk("rr_turn", 32'(owner_o), 32'h3);
        req_i = 2'b11;
        tick();
        tick();
        chk("rr_gnt", 32'(gnt_o), 32'h2);

        // Back to r0, then reset mid-read.
        req_i = 2'b01;
        tick(); tick(); tick();
        chk("mr_gnt", 32'(gnt_o), 32'h1);
        r0_cs_ni = 2'b10;
        #1;
        chk("mr_r0_dq", 32'(r0_dq_o), 32'h3C);
        rst_ni = 1'b0;
        #1;
        chk("mr_pad_cs", 32'(pad_cs_no), 32'h3);
        chk("mr_gnt_rst", 32'(gnt_o), 32'h0);
        chk("mr_r0_dq_rst", 32'(r0_dq_o), 32'h0);
        tick();
        r0_cs_ni = 2'b11; req_i = 2'b11;
        rst_ni = 1'b1;
        tick();
        chk("post_rst_tie", 32'(gnt_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
